data_mem_unit: RTL and testbench

Load/store unit directly downstream of the ALU in the RISC-V core: it takes the ALU result as a byte address and performs RV32I loads (LB/LH/LW/LBU/LHU) and stores (SB/SH/SW) on an internal single-port, synchronous-read word RAM. Sub-word stores use read-modify-write. Loads are sign- or zero-extended, and misaligned, out-of-range or illegal accesses are flagged. A request/ready/done handshake lets the multicycle control FSM stall on it.

---
 rtl/mem_pkg.sv | 49 ++++
 rtl/data_ram.sv | 28 ++
 rtl/data_mem_unit.sv | 158 +++++++++++++++
 tb/tb_data_mem_unit.sv | 262 ++++++++++++++++++++++++++
 4 files changed

// File: rtl/mem_pkg.sv
// Shared types, funct3 codes and lane helpers for the load/store unit.
// load_extend picks the addressed lane; store_merge splices store data into a word.
package mem_pkg;

    typedef enum logic [1:0] {
        IDLE,
        RD,
        WR,
        RESP
    } mem_state_t;

    localparam logic [2:0] F3_B  = 3'b000;
    localparam logic [2:0] F3_H  = 3'b001;
    localparam logic [2:0] F3_W  = 3'b010;
    localparam logic [2:0] F3_BU = 3'b100;
    localparam logic [2:0] F3_HU = 3'b101;

    function automatic logic [31:0] load_extend(input logic [31:0] word,
                                                input logic [1:0]  lane,
                                                input logic [2:0]  funct3);
        logic [31:0] shifted;
        shifted = word >> {lane, 3'b000};
        case (funct3)
            F3_B:    return {{24{shifted[7]}}, shifted[7:0]};
            F3_H:    return {{16{shifted[15]}}, shifted[15:0]};
            F3_W:    return word;
            F3_BU:   return {24'h000000, shifted[7:0]};
            F3_HU:   return {16'h0000, shifted[15:0]};
            default: return 32'h0000_0000;
        endcase
    endfunction

    // A full-word mask makes SW a plain overwrite through the same path.
    function automatic logic [31:0] store_merge(input logic [31:0] word,
                                                input logic [31:0] wdata,
                                                input logic [1:0]  lane,
                                                input logic [2:0]  funct3);
        logic [31:0] mask;
        logic [31:0] data;
        case (funct3)
            F3_B:    mask = 32'h0000_00FF << {lane, 3'b000};
            F3_H:    mask = 32'h0000_FFFF << {lane, 3'b000};
            default: mask = 32'hFFFF_FFFF;
        endcase
        data = wdata << {lane, 3'b000};
        return (word & ~mask) | (data & mask);
    endfunction

endpackage

// File: rtl/data_ram.sv
// Single-port DEPTH x 32 word RAM with synchronous read and write enable.
// The array is deliberately unreset so its contents survive a unit reset.
module data_ram #(
    parameter int DEPTH = 1024
) (
    input  logic                     clk_i,
    input  logic                     re_i,
    input  logic                     we_i,
    input  logic [$clog2(DEPTH)-1:0] addr_i,
    input  logic [31:0]              wdata_i,
    output logic [31:0]              rdata_o
);

    logic [31:0] mem_q [DEPTH];
    logic [31:0] rdata_q;

    always_ff @(posedge clk_i) begin
        if (we_i) begin
            mem_q[addr_i] <= wdata_i;
        end
        if (re_i) begin
            rdata_q <= mem_q[addr_i];
        end
    end

    assign rdata_o = rdata_q;

endmodule

// File: rtl/data_mem_unit.sv
// RV32I load/store unit: request latch, access checks, FSM and registered response
// around a synchronous word RAM, with a ready/done handshake for the core FSM.
module data_mem_unit
    import mem_pkg::*;
#(
    parameter int DEPTH = 1024
) (
    input  logic        clk_i,
    input  logic        rst_ni,
    input  logic        req_i,
    input  logic        we_i,
    input  logic [2:0]  funct3_i,
    input  logic [31:0] addr_i,
    input  logic [31:0] wdata_i,
    output logic        ready_o,
    output logic        done_o,
    output logic [31:0] rdata_o,
    output logic        err_o
);

    localparam int          AW         = $clog2(DEPTH);
    localparam logic [31:0] ADDR_LIMIT = 32'(4 * DEPTH);

    mem_state_t  state_q, state_d;
    logic        we_q;
    logic [2:0]  f3_q;
    logic [AW-1:0] idx_q;
    logic [1:0]  lane_q;
    logic [31:0] wdata_q;
    logic [31:0] rdata_q, rdata_d;
    logic        err_q, err_d;

    logic        f3Legal;
    logic        misaligned;
    logic        outOfRange;
    logic        reqErr;

    logic          ramRe;
    logic          ramWe;
    logic [AW-1:0] ramAddr;
    logic [31:0]   ramWdata;
    logic [31:0]   ramRdata;

    always_comb begin
        f3Legal = 1'b0;
        case (funct3_i)
            F3_B, F3_H, F3_W: f3Legal = 1'b1;
            F3_BU, F3_HU:     f3Legal = !we_i;
            default:          f3Legal = 1'b0;
        endcase
    end

    assign misaligned = ((funct3_i[1:0] == 2'b01) && addr_i[0]) ||
                        ((funct3_i == F3_W) && (addr_i[1:0] != 2'b00));
    assign outOfRange = (addr_i >= ADDR_LIMIT);
    assign reqErr     = !f3Legal || misaligned || outOfRange;

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            state_q <= IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    // Sub-word stores need the old word first, so they go through RD before WR.
    always_comb begin
        state_d = state_q;
        case (state_q)
            IDLE: begin
                if (req_i) begin
                    if (reqErr) begin
                        state_d = RESP;
                    end else if (!we_i || (funct3_i != F3_W)) begin
                        state_d = RD;
                    end else begin
                        state_d = WR;
                    end
                end
            end
            RD:      state_d = we_q ? WR : RESP;
            WR:      state_d = RESP;
            RESP:    state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    // The read is launched on the acceptance edge so the word is waiting in RD.
    always_comb begin
        ready_o  = (state_q == IDLE);
        done_o   = (state_q == RESP);
        ramRe    = (state_q == IDLE) && req_i && !reqErr;
        ramWe    = (state_q == WR);
        ramAddr  = (state_q == IDLE) ? addr_i[AW+1:2] : idx_q;
        ramWdata = store_merge(ramRdata, wdata_q, lane_q, f3_q);
    end

    always_comb begin
        rdata_d = rdata_q;
        err_d   = err_q;
        case (state_q)
            IDLE: begin
                if (req_i && reqErr) begin
                    rdata_d = 32'h0000_0000;
                    err_d   = 1'b1;
                end
            end
            RD: begin
                if (!we_q) begin
                    rdata_d = load_extend(ramRdata, lane_q, f3_q);
                    err_d   = 1'b0;
                end
            end
            WR: begin
                rdata_d = 32'h0000_0000;
                err_d   = 1'b0;
            end
            default: ;
        endcase
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            we_q    <= 1'b0;
            f3_q    <= 3'b000;
            idx_q   <= '0;
            lane_q  <= 2'b00;
            wdata_q <= 32'h0000_0000;
            rdata_q <= 32'h0000_0000;
            err_q   <= 1'b0;
        end else begin
            if ((state_q == IDLE) && req_i) begin
                we_q    <= we_i;
                f3_q    <= funct3_i;
                idx_q   <= addr_i[AW+1:2];
                lane_q  <= addr_i[1:0];
                wdata_q <= wdata_i;
            end
            rdata_q <= rdata_d;
            err_q   <= err_d;
        end
    end

    assign rdata_o = rdata_q;
    assign err_o   = err_q;

    data_ram #(
        .DEPTH(DEPTH)
    ) u_ram (
        .clk_i  (clk_i),
        .re_i   (ramRe),
        .we_i   (ramWe),
        .addr_i (ramAddr),
        .wdata_i(ramWdata),
        .rdata_o(ramRdata)
    );

endmodule

// File: tb/tb_data_mem_unit.sv
// Scoreboard bench for data_mem_unit: a byte-array model predicts each response,
// and a monitor compares data, error flag and latency whenever DONE is seen.
module tb_data_mem_unit;

    localparam int DEPTH = 1024;
    localparam int NBYTES = 4 * DEPTH;

    typedef struct {
        logic [31:0] rdata;
        logic        err;
        int          lat;
        int          acc;
    } exp_t;

    logic        clk = 1'b0;
    logic        rstN;
    logic        req;
    logic        we;
    logic [2:0]  funct3;
    logic [31:0] addr;
    logic [31:0] wdata;
    logic        ready;
    logic        done;
    logic [31:0] rdata;
    logic        err;

    int          tests = 0;
    int          fails = 0;
    int          cycle = 0;
    logic [31:0] lastRdata = 32'h0;
    logic [7:0]  modelMem [NBYTES];
    exp_t        sbQ[$];

    data_mem_unit #(
        .DEPTH(DEPTH)
    ) dut (
        .clk_i   (clk),
        .rst_ni  (rstN),
        .req_i   (req),
        .we_i    (we),
        .funct3_i(funct3),
        .addr_i  (addr),
        .wdata_i (wdata),
        .ready_o (ready),
        .done_o  (done),
        .rdata_o (rdata),
        .err_o   (err)
    );

    always #5 clk = ~clk;

    always @(posedge clk) cycle++;

    task automatic checkOutput(input string name, input logic [31:0] act, input logic [31:0] expv);
        tests++;
        if (act !== expv) begin
            fails++;
            $display("[TB] FAIL %s: got %08h, expected %08h", name, act, expv);
        end
    endtask

    function automatic bit accessError(input bit w, input logic [2:0] f3, input logic [31:0] a);
        bit legal;
        int size;
        legal = w ? (f3 inside {3'd0, 3'd1, 3'd2}) : (f3 inside {3'd0, 3'd1, 3'd2, 3'd4, 3'd5});
        if (!legal) return 1'b1;
        size = 1 << f3[1:0];
        if ((a % size) != 0) return 1'b1;
        if (a >= NBYTES) return 1'b1;
        return 1'b0;
    endfunction

    task automatic modelAccess(input bit w, input logic [2:0] f3, input logic [31:0] a,
                               input logic [31:0] wd, output exp_t e);
        int size;
        logic [31:0] v;
        e.acc = 0;
        if (accessError(w, f3, a)) begin
            e.rdata = 32'h0;
            e.err   = 1'b1;
            e.lat   = 1;
            return;
        end
        size = 1 << f3[1:0];
        e.err = 1'b0;
        if (w) begin
            for (int i = 0; i < size; i++) modelMem[a + i] = wd[8*i +: 8];
            e.rdata = 32'h0;
            e.lat   = (size == 4) ? 2 : 3;
        end else begin
            v = 32'h0;
            for (int i = 0; i < size; i++) v = v | (32'(modelMem[a + i]) << (8 * i));
            if (!f3[2] && size < 4 && v[8*size-1]) v = v | (32'hFFFF_FFFF << (8 * size));
            e.rdata = v;
            e.lat   = 2;
        end
    endtask

    task automatic applyStimulus(input bit w, input logic [2:0] f3, input logic [31:0] a,
                                 input logic [31:0] wd, input bit keepReq, input bit scramble,
                                 output int busy);
        exp_t e;
        int waits;
        we     = w;
        funct3 = f3;
        wdata  = wd;
        addr   = scramble ? $urandom : a;
        req    = 1'b1;
        waits  = 0;
        while (!ready && waits < 50) begin
            @(posedge clk);
            #1;
            waits++;
            if (scramble) addr = $urandom;
        end
        busy = waits;
        if (!ready) begin
            tests++;
            fails++;
            $display("[TB] FAIL accept_timeout: ready stuck at %0b, expected 1", ready);
            req = 1'b0;
            return;
        end
        addr = a;
        modelAccess(w, f3, a, wd, e);
        e.acc = cycle + 1;
        sbQ.push_back(e);
        @(posedge clk);
        #1;
        if (!keepReq) req = 1'b0;
    endtask

    always @(posedge clk) begin
        exp_t e;
        #1;
        if (rstN) begin
            if (done && ready) begin
                tests++;
                fails++;
                $display("[TB] FAIL done_ready_overlap: done=%0b ready=%0b, expected not both", done, ready);
            end
            if (done) begin
                if (sbQ.size() == 0) begin
                    tests++;
                    fails++;
                    $display("[TB] FAIL unexpected_done: rdata %08h with no pending request", rdata);
                end else begin
                    e = sbQ.pop_front();
                    checkOutput("rdata", rdata, e.rdata);
                    checkOutput("err", {31'b0, err}, {31'b0, e.err});
                    checkOutput("latency", 32'(cycle - e.acc + 1), 32'(e.lat));
                    lastRdata = e.rdata;
                end
            end
        end
    end

    initial begin
        int busy;
        int k;
        bit w;
        logic [2:0] f3;
        logic [31:0] a;
        int size;

        rstN = 1'b0; req = 1'b0; we = 1'b0; funct3 = 3'b000; addr = 32'h0; wdata = 32'h0;
        repeat (2) @(posedge clk);
        #1;
        checkOutput("reset_ready", {31'b0, ready}, 32'd1);
        checkOutput("reset_done", {31'b0, done}, 32'd0);
        checkOutput("reset_err", {31'b0, err}, 32'd0);
        checkOutput("reset_rdata", rdata, 32'h0);
        @(negedge clk) rstN = 1'b1;
        @(posedge clk);
        #1;

        for (int i = 0; i < 64; i++) applyStimulus(1'b1, 3'b010, 32'(4 * i), $urandom, 1'b0, 1'b0, busy);

        applyStimulus(1'b1, 3'b010, 32'h0C, 32'h8081_F2F3, 1'b0, 1'b0, busy);
        applyStimulus(1'b0, 3'b000, 32'h0C, 32'h0, 1'b0, 1'b0, busy);
        applyStimulus(1'b0, 3'b100, 32'h0D, 32'h0, 1'b0, 1'b0, busy);
        applyStimulus(1'b0, 3'b001, 32'h0E, 32'h0, 1'b0, 1'b0, busy);
        applyStimulus(1'b1, 3'b010, 32'h10, 32'h1234_5678, 1'b0, 1'b0, busy);
        applyStimulus(1'b0, 3'b010, 32'h10, 32'h0, 1'b0, 1'b0, busy);
        applyStimulus(1'b1, 3'b000, 32'h11, 32'h0000_00AB, 1'b0, 1'b0, busy);
        applyStimulus(1'b0, 3'b010, 32'h10, 32'h0, 1'b0, 1'b0, busy);
        applyStimulus(1'b1, 3'b001, 32'h12, 32'h0000_CDEF, 1'b0, 1'b0, busy);
        applyStimulus(1'b0, 3'b010, 32'h10, 32'h0, 1'b0, 1'b0, busy);

        applyStimulus(1'b0, 3'b010, 32'h06, 32'h0, 1'b0, 1'b0, busy);
        applyStimulus(1'b0, 3'b010, 32'h04, 32'h0, 1'b0, 1'b0, busy);
        applyStimulus(1'b0, 3'b001, 32'h03, 32'h0, 1'b0, 1'b0, busy);
        applyStimulus(1'b1, 3'b011, 32'h10, 32'hFFFF_FFFF, 1'b0, 1'b0, busy);
        applyStimulus(1'b1, 3'b100, 32'h10, 32'hFFFF_FFFF, 1'b0, 1'b0, busy);
        applyStimulus(1'b0, 3'b010, 32'h10, 32'h0, 1'b0, 1'b0, busy);
        applyStimulus(1'b1, 3'b010, 32'(NBYTES), 32'hFFFF_FFFF, 1'b0, 1'b0, busy);
        applyStimulus(1'b0, 3'b010, 32'(NBYTES), 32'h0, 1'b0, 1'b0, busy);
        applyStimulus(1'b0, 3'b010, 32'h00, 32'h0, 1'b0, 1'b0, busy);

        applyStimulus(1'b0, 3'b010, 32'h10, 32'h0, 1'b1, 1'b0, busy);
        applyStimulus(1'b0, 3'b000, 32'h0C, 32'h0, 1'b0, 1'b1, busy);
        checkOutput("busy_load", 32'(busy), 32'd2);
        applyStimulus(1'b1, 3'b000, 32'h11, 32'h0000_00AB, 1'b1, 1'b0, busy);
        applyStimulus(1'b0, 3'b010, 32'h10, 32'h0, 1'b0, 1'b1, busy);
        checkOutput("busy_sb", 32'(busy), 32'd3);

        applyStimulus(1'b1, 3'b010, 32'h20, 32'h0, 1'b0, 1'b0, busy);
        applyStimulus(1'b0, 3'b010, 32'h10, 32'h0, 1'b0, 1'b0, busy);
        repeat (3) @(posedge clk);
        #1;
        we = 1'b1; funct3 = 3'b010; addr = 32'h20; wdata = 32'hDEAD_BEEF; req = 1'b1;
        @(posedge clk);
        #1;
        req = 1'b0;
        rstN = 1'b0;
        #1;
        checkOutput("midreset_ready", {31'b0, ready}, 32'd1);
        checkOutput("midreset_done", {31'b0, done}, 32'd0);
        checkOutput("midreset_rdata", rdata, 32'h0);
        @(posedge clk);
        @(negedge clk) rstN = 1'b1;
        @(posedge clk);
        #1;
        applyStimulus(1'b0, 3'b010, 32'h20, 32'h0, 1'b0, 1'b0, busy);

        for (int i = 0; i < 300; i++) begin
            w = 1'($urandom_range(0, 1));
            if ($urandom_range(0, 19) < 18) begin
                if (w) begin
                    f3 = 3'($urandom_range(0, 2));
                end else begin
                    k  = $urandom_range(0, 4);
                    f3 = (k < 3) ? 3'(k) : 3'(k + 1);
                end
            end else begin
                k  = $urandom_range(0, 2);
                f3 = (k == 0) ? 3'b011 : ((k == 1) ? 3'b110 : 3'b111);
            end
            size = 1 << f3[1:0];
            k = $urandom_range(0, 19);
            if (k == 0) a = 32'(NBYTES) + 32'($urandom_range(0, 63));
            else if (k == 1) a = 32'($urandom_range(0, 255));
            else a = 32'($urandom_range(0, 255)) & ~32'(size - 1);
            applyStimulus(w, f3, a, $urandom, 1'b0, 1'b0, busy);
        end

        k = 0;
        while (sbQ.size() != 0 && k < 20) begin
            @(posedge clk);
            #1;
            k++;
        end
        checkOutput("drain", 32'(sbQ.size()), 32'd0);
        repeat (3) @(posedge clk);
        #1;
        checkOutput("rdata_hold", rdata, lastRdata);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
